p4_router_vnp4_ingress_arb: RTL and testbench
=============================================

# p4_router_vnp4_ingress_arb

Packet-level arbiter that shares one Vitis Networking P4 pipeline (echo-physical-port configuration, 512-bit AXIS, 33-bit user metadata) between NUM_PORTS physical-port ingress streams. It grants whole packets round-robin, or by strict priority when configured. It builds the pipeline's USER_META_DATA_T word {ing_port, egr_spec, prio, byte_length} and drives the pipeline's slave AXIS through a registered skid stage. It sits between the port MAC/ingress adapters and the VNP4 instance.

## Interface
- NUM_PORTS, 4: number of requesters, 2..8.
- DATA_WIDTH, 512: AXIS tdata width.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- PORT_ID_BASE, 0: ing_port value for requester 0; requester i is PORT_ID_BASE+i, 8 bits.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data, port i at slice i.
- s_axis_tkeep  in  NUM_PORTS*KEEP_WIDTH  per-port byte enables.
- s_axis_tuser  in  NUM_PORTS*17  per-port {prio[2:0], byte_length[13:0]}; valid on the first beat.
- s_axis_tlast  in  NUM_PORTS  end of packet.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready; at most one bit high.
- m_axis_tdata  out  DATA_WIDTH  to VNP4 s_axis.
- m_axis_tkeep  out  KEEP_WIDTH  to VNP4.
- m_axis_tlast  out  1  to VNP4.
- m_axis_tvalid  out  1  to VNP4.
- m_axis_tready  in  1  from VNP4.
- m_user_metadata  out  33  USER_META_DATA_T: [32:25] ing_port, [24:17] egr_spec, [16:14] prio, [13:0] byte_length.
- grant_onehot  out  NUM_PORTS  current owner; zero when idle.
- pkt_count  out  32  packets forwarded (tlast accepted on m_axis); wraps.

## Operation
- FSM has two states, IDLE and ACTIVE.
- IDLE: all s_axis_tready low. If any s_axis_tvalid is high, select a winner and register it into grant_onehot, then go to ACTIVE on the next edge.
- Round-robin selection: search starts at last_grant+1 modulo NUM_PORTS. After reset, last_grant = NUM_PORTS-1, so port 0 wins first.
- ACTIVE: s_axis_tready[g] = skid-buffer not full. Other ports' tready is low.
- First accepted beat of a packet: latch ing_port = PORT_ID_BASE+g, prio, and byte_length from s_axis_tuser[g]. egr_spec = 8'h00.
- Latched metadata is held on m_user_metadata for every beat of the packet.
- Accepted beat with tlast: update last_grant = g, clear grant_onehot, return to IDLE.
- tuser on non-first beats is ignored.
- Skid stage holds 2 entries of {data, keep, last, metadata}.
  - m_axis_tvalid = not empty.
  - Pop on m_axis_tvalid & m_axis_tready; push on an accepted input beat.
  - Simultaneous push and pop keeps the occupancy unchanged.
  - Never overflow; input is accepted only when an entry is free or a pop occurs in the same cycle.
- The owner may drop tvalid mid-packet. The grant is held with no timeout, and no other port is served.
- A requester that drops tvalid while waiting in IDLE simply loses that arbitration round.
- Reset (asynchronous assert, any time including mid-packet):
  - state = IDLE, grant_onehot = 0, skid empty, last_grant = NUM_PORTS-1, pkt_count = 0.
  - All outputs 0: m_axis_tvalid=0, s_axis_tready=0, m_user_metadata=0.
  - Partial packets are discarded. Reset deassertion is synchronised to clk internally.

## Timing
- Arbitration latency: 1 cycle in IDLE; s_axis_tready rises on the cycle after the request is first seen.
- Input-to-output latency: an accepted beat appears on m_axis 1 cycle later when the skid is empty.
- Throughput: 1 beat/cycle within a packet. There is exactly 1 idle input cycle between consecutive packets (the IDLE arbitration cycle).
- m_axis signals come only from the skid registers; no combinational path from s_axis to m_axis.
- m_axis_tready does reach s_axis_tready combinationally, through the full/pop logic.

## Configuration
- P4_ROUTER_VNP4_ARB_STRICT_PRIO_EN defined:
  - IDLE picks the requester whose first-beat tuser prio is highest; 7 is highest.
  - Ties are broken round-robin from last_grant+1.
- Not defined: pure round-robin; prio is still latched and forwarded unchanged.

## Test plan
- Single port: port 2, PORT_ID_BASE=16, 3-beat packet with tuser={3'd5,14'd150} -> 3 m_axis beats, tlast on beat 3, m_user_metadata = {8'd18, 8'd0, 3'd5, 14'd150} on all beats, pkt_count=1.
- Round-robin fairness: all 4 ports continuously send 2-beat packets -> grant order 0,1,2,3,0,…; one input bubble between packets; pkt_count=8 after 8 packets.
- Backpressure: m_axis_tready toggles 1010… during an 8-beat packet -> no beat lost or duplicated, tdata order preserved, skid never exceeds 2 entries.
- Strict priority (macro defined): port 0 prio 1 and port 3 prio 6 request together -> port 3 granted first. Without the macro, port 0 is granted first.
- Reset mid-packet: assert rst_n low on beat 2 of a 5-beat packet -> all outputs 0 asynchronously. After release, a new packet from port 1 is forwarded intact with correct metadata, and pkt_count restarts from 0.
- Owner stall: granted port drops tvalid for 10 cycles mid-packet while port 1 requests -> port 1 stays unserved until the owner's tlast, then is granted.

Source files
------------

// File: rtl/p4_router_vnp4_ingress_arb.sv
//-----------------------------------------------------------------------------
// p4_router_vnp4_ingress_arb
// Packet-level arbiter sharing one VNP4 pipeline between NUM_PORTS ingress
// AXIS streams. Grants whole packets round-robin (or by strict priority when
// P4_ROUTER_VNP4_ARB_STRICT_PRIO_EN is defined), builds the 33-bit
// USER_META_DATA_T word {ing_port, egr_spec, prio, byte_length} and drives the
// pipeline through a 2-entry registered skid stage.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module p4_router_vnp4_ingress_arb #(
   parameter int unsigned NUM_PORTS    = 4,
   parameter int unsigned DATA_WIDTH   = 512,
   parameter int unsigned KEEP_WIDTH   = DATA_WIDTH/8,
   parameter int unsigned PORT_ID_BASE = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
   input  logic [NUM_PORTS*17-1:0]          s_axis_tuser,
   input  logic [NUM_PORTS-1:0]             s_axis_tlast,
   input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
   output logic [NUM_PORTS-1:0]             s_axis_tready,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
   output logic                             m_axis_tlast,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [32:0]                      m_user_metadata,
   output logic [NUM_PORTS-1:0]             grant_onehot,
   output logic [31:0]                      pkt_count
);

   localparam int unsigned IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned TUSER_W = 17;
   localparam int unsigned META_W  = 33;
   localparam int unsigned PRIO_LO = 14;
   localparam int unsigned CNT_W   = 2;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [KEEP_WIDTH-1:0] keep;
      logic                  last;
      logic [META_W-1:0]     meta;
   } beat_t;

   // round-robin candidate index: (last + step) mod NUM_PORTS
   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] last,
                                                input int unsigned      step);
      int unsigned s;
      s = 32'(last) + step;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      return IDX_W'(s);
   endfunction

   // reset synchroniser: asynchronous assert, clk-synchronous release
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   // state
   state_t                r_state;
   state_t                w_state_nxt;
   logic [NUM_PORTS-1:0]  r_grant_onehot;
   logic [IDX_W-1:0]      r_last_grant;
   logic                  r_first;
   logic [META_W-1:0]     r_meta;
   logic [31:0]           r_pkt_count;
   beat_t                 r_ent0;
   beat_t                 r_ent1;
   logic [CNT_W-1:0]      r_count;

   // combinational
   logic [IDX_W-1:0]      w_gidx;
   logic [DATA_WIDTH-1:0] w_in_data;
   logic [KEEP_WIDTH-1:0] w_in_keep;
   logic [TUSER_W-1:0]    w_in_user;
   logic                  w_in_last;
   logic                  w_in_fire;
   logic                  w_pop;
   logic                  w_skid_room;
   logic                  w_arb_load;
   logic                  w_win_found;
   logic [IDX_W-1:0]      w_win_idx;
   logic [IDX_W-1:0]      w_rr_p;
   logic [NUM_PORTS-1:0]  w_win_onehot;
   logic [META_W-1:0]     w_beat_meta;
   beat_t                 w_push;
`ifdef P4_ROUTER_VNP4_ARB_STRICT_PRIO_EN
   logic [2:0]            w_rr_prio;
   logic [2:0]            w_win_prio;
`endif

   // two-flop reset release synchroniser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   // encode the current owner index from the one-hot grant
   always_comb begin
      w_gidx = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (r_grant_onehot[i]) w_gidx = IDX_W'(i);
      end
   end

   // mux the owner's AXIS fields
   always_comb begin
      w_in_data = '0;
      w_in_keep = '0;
      w_in_user = '0;
      w_in_last = 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (r_grant_onehot[i]) begin
            w_in_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            w_in_keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            w_in_user = s_axis_tuser[i*TUSER_W +: TUSER_W];
            w_in_last = s_axis_tlast[i];
         end
      end
   end

   // pick the next owner, scanning from last_grant+1
   always_comb begin
      w_win_found = 1'b0;
      w_win_idx   = '0;
      w_rr_p      = '0;
`ifdef P4_ROUTER_VNP4_ARB_STRICT_PRIO_EN
      w_rr_prio   = '0;
      w_win_prio  = '0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         w_rr_p    = rr_idx(r_last_grant, k);
         w_rr_prio = s_axis_tuser[32'(w_rr_p)*TUSER_W + PRIO_LO +: 3];
         // strictly-greater keeps the earliest round-robin candidate on ties
         if (s_axis_tvalid[w_rr_p] && (!w_win_found || (w_rr_prio > w_win_prio))) begin
            w_win_found = 1'b1;
            w_win_idx   = w_rr_p;
            w_win_prio  = w_rr_prio;
         end
      end
`else
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         w_rr_p = rr_idx(r_last_grant, k);
         if (s_axis_tvalid[w_rr_p] && !w_win_found) begin
            w_win_found = 1'b1;
            w_win_idx   = w_rr_p;
         end
      end
`endif
   end

   assign w_win_onehot = NUM_PORTS'(1) << w_win_idx;

   // skid handshake: room when not full, or when the head leaves this cycle
   assign m_axis_tvalid = (r_count != CNT_W'(0));
   assign w_pop         = m_axis_tvalid & m_axis_tready;
   assign w_skid_room   = (r_count != CNT_W'(2)) | w_pop;
   assign w_in_fire     = |(s_axis_tvalid & s_axis_tready);

   // FSM state register
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (|s_axis_tvalid)          w_state_nxt = S_ACTIVE;
         S_ACTIVE: if (w_in_fire && w_in_last)  w_state_nxt = S_IDLE;
         default:                               w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: owner ready and arbitration load strobe
   always_comb begin
      s_axis_tready = '0;
      w_arb_load    = 1'b0;
      case (r_state)
         S_IDLE:   w_arb_load    = w_win_found;
         S_ACTIVE: s_axis_tready = r_grant_onehot & {NUM_PORTS{w_skid_room}};
         default:  w_arb_load    = 1'b0;
      endcase
   end

   // metadata is taken from the first beat's tuser and reused for the rest
   assign w_beat_meta = r_first ?
                        {8'(PORT_ID_BASE + 32'(w_gidx)), 8'h00, w_in_user} :
                        r_meta;
   assign w_push      = {w_in_data, w_in_keep, w_in_last, w_beat_meta};

   // grant ownership, last_grant history and per-packet metadata latch
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_grant_onehot <= '0;
         r_last_grant   <= IDX_W'(NUM_PORTS - 1);
         r_first        <= 1'b0;
         r_meta         <= '0;
      end else if (w_arb_load) begin
         r_grant_onehot <= w_win_onehot;
         r_first        <= 1'b1;
      end else if (w_in_fire) begin
         r_first <= 1'b0;
         r_meta  <= w_beat_meta;
         if (w_in_last) begin
            r_grant_onehot <= '0;
            r_last_grant   <= w_gidx;
         end
      end
   end

   // 2-entry skid: ent0 is the head driven onto m_axis
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_ent0  <= '0;
         r_ent1  <= '0;
         r_count <= '0;
      end else begin
         case ({w_in_fire, w_pop})
            2'b10: begin
               if (r_count == CNT_W'(0)) r_ent0 <= w_push;
               else                      r_ent1 <= w_push;
               r_count <= r_count + CNT_W'(1);
            end
            2'b01: begin
               r_ent0  <= r_ent1;
               r_count <= r_count - CNT_W'(1);
            end
            2'b11: begin
               if (r_count == CNT_W'(1)) begin
                  r_ent0 <= w_push;
               end else begin
                  r_ent0 <= r_ent1;
                  r_ent1 <= w_push;
               end
            end
            default: r_count <= r_count;
         endcase
      end
   end

   // forwarded packet counter (tlast leaving on m_axis)
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n)                 r_pkt_count <= '0;
      else if (w_pop && r_ent0.last) r_pkt_count <= r_pkt_count + 32'd1;
   end

   assign m_axis_tdata    = r_ent0.data;
   assign m_axis_tkeep    = r_ent0.keep;
   assign m_axis_tlast    = r_ent0.last;
   assign m_user_metadata = r_ent0.meta;
   assign grant_onehot    = r_grant_onehot;
   assign pkt_count       = r_pkt_count;

endmodule

// File: tb/tb_p4_router_vnp4_ingress_arb.sv
//-----------------------------------------------------------------------------
// Self-checking bench for p4_router_vnp4_ingress_arb: table of scenarios
// (directed + randomized) run against a packet-level reference model, plus a
// hand-written mid-packet reset sequence.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_p4_router_vnp4_ingress_arb;

   localparam int unsigned NP    = 4;
   localparam int unsigned DW    = 64;
   localparam int unsigned KW    = DW/8;
   localparam int unsigned PBASE = 16;
   localparam int unsigned MAXPK = 8;
   localparam int unsigned NVEC  = 9;
`ifdef P4_ROUTER_VNP4_ARB_STRICT_PRIO_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NP*DW-1:0]  s_tdata = '0;
   logic [NP*KW-1:0]  s_tkeep = '0;
   logic [NP*17-1:0]  s_tuser = '0;
   logic [NP-1:0]     s_tlast = '0;
   logic [NP-1:0]     s_tvalid = '0;
   logic [NP-1:0]     s_tready;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic              m_tlast;
   logic              m_tvalid;
   logic              m_tready = 1'b0;
   logic [32:0]       m_meta;
   logic [NP-1:0]     grant;
   logic [31:0]       pkt_count;

   always #5 clk = ~clk;

   p4_router_vnp4_ingress_arb #(
      .NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .PORT_ID_BASE(PBASE)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
      .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_user_metadata(m_meta), .grant_onehot(grant), .pkt_count(pkt_count)
   );

   typedef struct packed {
      logic [NP-1:0][3:0] npk;       // packets per port
      logic [3:0]         len;       // beats per packet, 0 = random 1..6
      logic [NP-1:0][2:0] prio;
      logic [13:0]        blen;      // 0 = random
      logic               rnd_prio;
      logic [1:0]         rdy_mode;  // 0 always, 1 toggle 1010, 2 random
      logic               drop;      // owner drops tvalid randomly mid-packet
      logic               stall;     // port 0 stalls 10 cycles at beat 2
      logic               chk_first;
      logic [1:0]         exp_first;
      logic               chk_span;
      logic [7:0]         exp_pkts;
   } vec_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [32:0]   meta;
   } beat_t;

   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;

   // source state
   int unsigned npk[NP], k_cur[NP], b_cur[NP];
   int unsigned plen[NP][MAXPK];
   logic [2:0]  pprio[NP][MAXPK];
   logic [13:0] pblen[NP][MAXPK];
   bit          drop_en;
   int unsigned rdy_mode;
   int          stall_port;
   int unsigned stall_beat, stall_left;
   bit          stalling;

   // scoreboard
   beat_t       exp_out[$];
   int unsigned exp_in[$];
   int unsigned outstanding, acc_total, cyc;
   int unsigned first_acc_cyc, last_acc_cyc;
   logic [NP-1:0] first_acc_mask;
   bit          seen_acc;

   vec_t vt[NVEC];

   task automatic check(input bit ok, input string name,
                        input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [DW-1:0] beat_data(input int unsigned p, k, b);
      return DW'(64'hC0DE_0000_0000_0000 | (64'(p) << 40) | (64'(k) << 20) | 64'(b));
   endfunction

   // packet-level reference: whole packets in arbitration order
   task automatic build_expect();
      int unsigned rem[NP], kk[NP], last, p;
      int          pick;
      logic [2:0]  bp, pr;
      last = NP - 1;
      for (int i = 0; i < NP; i++) begin rem[i] = npk[i]; kk[i] = 0; end
      while (1) begin
         pick = -1; bp = '0;
         for (int i = 1; i <= NP; i++) begin
            p = (last + i) % NP;
            if (rem[p] > 0) begin
               pr = STRICT ? pprio[p][kk[p]] : 3'd0;
               if (pick < 0 || pr > bp) begin pick = int'(p); bp = pr; end
            end
         end
         if (pick < 0) break;
         p = pick;
         for (int unsigned b = 0; b < plen[p][kk[p]]; b++) begin
            exp_out.push_back({beat_data(p, kk[p], b),
                               (b == plen[p][kk[p]] - 1) ? 8'h3F : 8'hFF,
                               b == plen[p][kk[p]] - 1,
                               8'(PBASE + p), 8'h00, pprio[p][kk[p]], pblen[p][kk[p]]});
            exp_in.push_back(p);
         end
         rem[p]--; kk[p]++; last = p;
      end
   endtask

   task automatic drive();
      int unsigned k, b;
      stalling = 1'b0;
      for (int unsigned p = 0; p < NP; p++) begin
         s_tvalid[p] = 1'b0;
         s_tlast[p]  = 1'b0;
         s_tdata[p*DW +: DW] = '0;
         s_tkeep[p*KW +: KW] = '0;
         s_tuser[p*17 +: 17] = 17'($urandom);
         if (k_cur[p] < npk[p]) begin
            k = k_cur[p]; b = b_cur[p];
            s_tdata[p*DW +: DW] = beat_data(p, k, b);
            s_tlast[p]          = (b == plen[p][k] - 1);
            s_tkeep[p*KW +: KW] = s_tlast[p] ? 8'h3F : 8'hFF;
            if (b == 0) s_tuser[p*17 +: 17] = {pprio[p][k], pblen[p][k]};
            s_tvalid[p] = 1'b1;
            if (drop_en && b > 0 && $urandom_range(0, 3) == 0) s_tvalid[p] = 1'b0;
            if (int'(p) == stall_port && b == stall_beat && stall_left > 0) begin
               s_tvalid[p] = 1'b0;
               stall_left--;
               stalling = 1'b1;
            end
         end
      end
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = (cyc % 2 == 0);
         default: m_tready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // one clock: sample/check at negedge, advance sources after posedge
   task automatic step();
      logic [NP-1:0] acc, own;
      bit            pop;
      beat_t         got, e;
      int unsigned   ep;
      @(negedge clk);
      acc = s_tvalid & s_tready;
      pop = m_tvalid & m_tready;
      check($onehot0(s_tready), "tready_onehot0", 128'(s_tready), 128'(0));
      check(m_tvalid == (outstanding != 0), "m_tvalid", 128'(m_tvalid), 128'(outstanding != 0));
      if (stalling) begin
         own = NP'(1) << stall_port;
         check(grant == own && (s_tready & ~own) == '0, "stall_hold",
               128'({grant, s_tready}), 128'({own, 4'h0}));
      end
      if (pop) begin
         got = {m_tdata, m_tkeep, m_tlast, m_meta};
         if (exp_out.size() == 0) check(1'b0, "extra_beat", 128'(got), 128'(0));
         else begin
            e = exp_out.pop_front();
            check(got == e, "beat", 128'(got), 128'(e));
         end
         if (outstanding > 0) outstanding--;
      end
      if (acc != '0) begin
         if (exp_in.size() == 0) check(1'b0, "extra_accept", 128'(acc), 128'(0));
         else begin
            ep = exp_in.pop_front();
            check(acc == (NP'(1) << ep) && grant == acc, "owner",
                  128'({grant, acc}), 128'({NP'(1) << ep, NP'(1) << ep}));
         end
         if (!seen_acc) begin first_acc_cyc = cyc; first_acc_mask = acc; end
         seen_acc = 1'b1;
         last_acc_cyc = cyc;
         outstanding++;
         acc_total++;
      end
      check(outstanding <= 2, "skid_depth", 128'(outstanding), 128'(2));
      @(posedge clk); #1;
      for (int unsigned p = 0; p < NP; p++) begin
         if (acc[p]) begin
            if (s_tlast[p]) begin b_cur[p] = 0; k_cur[p]++; end
            else b_cur[p]++;
         end
      end
      cyc++;
      drive();
   endtask

   task automatic clear_src();
      for (int p = 0; p < NP; p++) begin npk[p] = 0; k_cur[p] = 0; b_cur[p] = 0; end
      exp_out.delete(); exp_in.delete();
      outstanding = 0; acc_total = 0; cyc = 0; seen_acc = 1'b0;
      drop_en = 1'b0; rdy_mode = 0; stall_port = -1; stall_left = 0; stalling = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_src();
      s_tvalid = '0; m_tready = 1'b0;
      repeat (2) @(posedge clk); #1;
      check({m_tvalid, s_tready, grant, pkt_count, m_meta, m_tdata} == '0, "reset_state",
            128'({m_tvalid, s_tready, grant, pkt_count, m_meta}), 128'(0));
      rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
   endtask

   task automatic run_traffic(input int unsigned stop_acc);
      drive();
      while ((stop_acc == 0 ? exp_out.size() > 0 : acc_total < stop_acc) && cyc < 3000) step();
      if (stop_acc == 0) check(exp_out.size() == 0, "drain_timeout", 128'(exp_out.size()), 128'(0));
      else check(acc_total >= stop_acc, "accept_timeout", 128'(acc_total), 128'(stop_acc));
   endtask

   task automatic run_vector(input vec_t v);
      int unsigned beats, pkts;
      do_reset();
      beats = 0; pkts = 0;
      for (int unsigned p = 0; p < NP; p++) begin
         npk[p] = v.npk[p];
         for (int unsigned k = 0; k < npk[p]; k++) begin
            plen[p][k]  = (v.len != 0) ? int'(v.len) : $urandom_range(1, 6);
            pprio[p][k] = v.rnd_prio ? 3'($urandom) : v.prio[p];
            pblen[p][k] = (v.blen != 0) ? v.blen : 14'($urandom_range(1, 9000));
            beats += plen[p][k];
            pkts++;
         end
      end
      drop_en = v.drop;
      rdy_mode = v.rdy_mode;
      if (v.stall) begin stall_port = 0; stall_beat = 2; stall_left = 10; end
      build_expect();
      run_traffic(0);
      @(negedge clk);
      check(pkt_count == 32'(v.exp_pkts), "pkt_count", 128'(pkt_count), 128'(v.exp_pkts));
      if (v.chk_first)
         check(first_acc_mask == (NP'(1) << v.exp_first), "first_grant",
               128'(first_acc_mask), 128'(NP'(1) << v.exp_first));
      if (v.chk_span)
         check(last_acc_cyc - first_acc_cyc + 1 == beats + pkts - 1, "input_span",
               128'(last_acc_cyc - first_acc_cyc + 1), 128'(beats + pkts - 1));
      clear_src();
      drive();
   endtask

   initial begin
      int unsigned sum;
      // 0: single port 2, metadata {18,0,5,150}
      vt[0] = '0; vt[0].npk[2] = 1; vt[0].len = 3; vt[0].prio[2] = 5; vt[0].blen = 150;
      vt[0].chk_first = 1; vt[0].exp_first = 2; vt[0].exp_pkts = 1;
      // 1: all ports, 2 packets of 2 beats, continuous: 0,1,2,3,0,...
      vt[1] = '0; vt[1].npk = {4'd2, 4'd2, 4'd2, 4'd2}; vt[1].len = 2; vt[1].blen = 64;
      vt[1].chk_first = 1; vt[1].exp_first = 0; vt[1].chk_span = 1; vt[1].exp_pkts = 8;
      // 2: 8-beat packet under 1010 backpressure
      vt[2] = '0; vt[2].npk[1] = 1; vt[2].len = 8; vt[2].prio[1] = 2; vt[2].blen = 512;
      vt[2].rdy_mode = 1; vt[2].chk_first = 1; vt[2].exp_first = 1; vt[2].exp_pkts = 1;
      // 3: port 0 prio 1 vs port 3 prio 6
      vt[3] = '0; vt[3].npk[0] = 1; vt[3].npk[3] = 1; vt[3].len = 2;
      vt[3].prio[0] = 1; vt[3].prio[3] = 6; vt[3].blen = 100;
      vt[3].chk_first = 1; vt[3].exp_first = STRICT ? 2'd3 : 2'd0; vt[3].exp_pkts = 2;
      // 4: owner stall with port 1 waiting
      vt[4] = '0; vt[4].npk[0] = 1; vt[4].npk[1] = 1; vt[4].len = 4; vt[4].blen = 200;
      vt[4].stall = 1; vt[4].chk_first = 1; vt[4].exp_first = 0; vt[4].exp_pkts = 2;
      // 5..8: randomized traffic
      for (int i = 5; i < NVEC; i++) begin
         vt[i] = '0; sum = 0;
         for (int p = 0; p < NP; p++) begin
            vt[i].npk[p] = 4'($urandom_range(p == 0 ? 1 : 0, 3));
            sum += vt[i].npk[p];
         end
         vt[i].rnd_prio = 1; vt[i].rdy_mode = 2; vt[i].drop = 1; vt[i].exp_pkts = 8'(sum);
      end

      clear_src();
      for (int i = 0; i < NVEC; i++) run_vector(vt[i]);

      // mid-packet reset: port 2 sends 2-beat then 5-beat packet, reset on beat 2 of the second
      do_reset();
      npk[2] = 2;
      plen[2][0] = 2; pprio[2][0] = 3'd4; pblen[2][0] = 14'd90;
      plen[2][1] = 5; pprio[2][1] = 3'd3; pblen[2][1] = 14'd300;
      rdy_mode = 0;
      build_expect();
      run_traffic(4);
      check(pkt_count == 32'd1, "pkt_before_reset", 128'(pkt_count), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      check({m_tvalid, m_tlast, m_tdata, m_meta, s_tready, grant, pkt_count} == '0, "async_reset",
            128'({m_tvalid, m_meta, s_tready, grant, pkt_count}), 128'(0));
      clear_src();
      drive();
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      check(pkt_count == 32'd0, "pkt_after_reset", 128'(pkt_count), 128'(0));
      npk[1] = 1; plen[1][0] = 3; pprio[1][0] = 3'd2; pblen[1][0] = 14'd77;
      build_expect();
      run_traffic(0);
      @(negedge clk);
      check(pkt_count == 32'd1, "pkt_restart", 128'(pkt_count), 128'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
